// File: rtl/demux4_seq.sv
// demux4_seq: 1-to-4 demultiplexer with a one-entry holding register per output channel.
// Optional auto round-robin distribution is built only when DEMUX_AUTO_EN is defined.
module demux4_seq #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   d,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     select,
  input  logic           auto,
  output logic [4*W-1:0] q,
  output logic [3:0]     q_valid,
  input  logic [3:0]     q_ready
);

  logic [W-1:0] data_q [4];
  logic [W-1:0] data_d [4];
  logic [3:0]   v_q;
  logic [3:0]   v_d;
  logic [1:0]   tgt;
  logic         accept;

`ifdef DEMUX_AUTO_EN
  logic [1:0] ptr_q;
  logic [1:0] ptr_d;

  always_comb begin
    tgt = auto ? ptr_q : select;
  end

  // Pointer moves only on an actual accept in auto mode; toggling auto leaves it alone.
  always_comb begin
    ptr_d = ptr_q;
    if (accept && auto) begin
      ptr_d = ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  logic auto_unused;
  assign auto_unused = auto;

  always_comb begin
    tgt = select;
  end
`endif

  always_comb begin
    in_ready = !v_q[tgt] || q_ready[tgt];
    accept   = in_valid && in_ready;
  end

  // Drain and reload of the same channel on one edge: the accept wins and keeps v set.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      v_d[i]    = v_q[i] && !q_ready[i];
      data_d[i] = data_q[i];
      if (accept && (tgt == 2'(i))) begin
        v_d[i]    = 1'b1;
        data_d[i] = d;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int unsigned i = 0; i < 4; i++) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    q = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      q[i*W +: W] = data_q[i];
    end
    q_valid = v_q;
  end

endmodule

// File: tb/tb_demux4_seq.sv
// Scoreboard bench for demux4_seq: expected words queued per channel, monitor pops on drain.
// Auto-mode scenarios are compiled when DEMUX_AUTO_EN is defined, manual-only otherwise.
module tb_demux4_seq;

  localparam int unsigned W = 4;

  logic           clk;
  logic           reset;
  logic [W-1:0]   d;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     select;
  logic           auto;
  logic [4*W-1:0] q;
  logic [3:0]     q_valid;
  logic [3:0]     q_ready;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q [4][$];

  demux4_seq #(.W(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .d        (d),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .select   (select),
    .auto     (auto),
    .q        (q),
    .q_valid  (q_valid),
    .q_ready  (q_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every drain handshake must match the oldest word queued for that channel.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (q_valid[i] && q_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_ch%0d: got %0h expected no data", i, q[i*W +: W]);
          end else begin
            chk($sformatf("drain_ch%0d", i), 64'(q[i*W +: W]), 64'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; d = '0; in_valid = 1'b0; select = '0; auto = 1'b0; q_ready = '0;
    #12;
    chk("rst_q", 64'(q), 64'h0);
    chk("rst_qvalid", 64'(q_valid), 64'h0);
    chk("rst_inready", 64'(in_ready), 64'h1);
    cyc();
    reset = 1'b0;
    #1;
    chk("post_rst_inready", 64'(in_ready), 64'h1);

    // single word to channel 2, held while its consumer stalls
    select = 2'd2; d = 4'b0110; in_valid = 1'b1;
    chk("c2_inready", 64'(in_ready), 64'h1);
    exp_q[2].push_back(4'b0110);
    cyc();
    in_valid = 1'b0;
    chk("c2_qvalid", 64'(q_valid), 64'h4);
    chk("c2_data", 64'(q[11:8]), 64'h6);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; d = 4'(k + 9);
      #1;
      chk("c2_blocked", 64'(in_ready), 64'h0);
      cyc();
      chk("c2_hold", 64'(q[11:8]), 64'h6);
    end
    in_valid = 1'b0;
    q_ready = 4'b0100;
    cyc();
    q_ready = '0;
    chk("c2_empty", 64'(q_valid), 64'h0);

    // full channel 1 refuses, then drains and reloads on the same edge
    select = 2'd1; d = 4'h3; in_valid = 1'b1;
    exp_q[1].push_back(4'h3);
    cyc();
    d = 4'h5;
    #1;
    chk("c1_blocked", 64'(in_ready), 64'h0);
    cyc();
    chk("c1_hold", 64'(q[7:4]), 64'h3);
    q_ready = 4'b0010; d = 4'hA;
    #1;
    chk("c1_ready_pass", 64'(in_ready), 64'h1);
    exp_q[1].push_back(4'hA);
    cyc();
    in_valid = 1'b0; q_ready = '0;
    chk("c1_reload", 64'(q[7:4]), 64'hA);
    chk("c1_qvalid", 64'(q_valid), 64'h2);
    q_ready = 4'b0010;
    cyc();
    q_ready = '0;

    // three channels drain together while channel 0 reloads
    for (int k = 0; k < 3; k++) begin
      logic [1:0] ch;
      ch = (k == 2) ? 2'd3 : 2'(k);
      select = ch; d = 4'(k + 1); in_valid = 1'b1;
      exp_q[ch].push_back(4'(k + 1));
      cyc();
    end
    chk("multi_qvalid", 64'(q_valid), 64'hB);
    select = 2'd0; d = 4'h7; q_ready = 4'b1111;
    exp_q[0].push_back(4'h7);
    cyc();
    in_valid = 1'b0; q_ready = '0;
    chk("multi_after", 64'(q_valid), 64'h1);
    chk("multi_c0", 64'(q[3:0]), 64'h7);
    q_ready = 4'b0001;
    cyc();
    q_ready = '0;
    chk("multi_empty", 64'(q_valid), 64'h0);

`ifdef DEMUX_AUTO_EN
    // round robin over six words leaves the pointer at 2
    auto = 1'b1; q_ready = 4'b1111; in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      d = 4'(k + 1);
      exp_q[k % 4].push_back(4'(k + 1));
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    q_ready = '0;
    chk("rr_empty", 64'(q_valid), 64'h0);
    // manual fill of channel 2 must not move the pointer
    auto = 1'b0; select = 2'd2; d = 4'h9; in_valid = 1'b1;
    exp_q[2].push_back(4'h9);
    cyc();
    auto = 1'b1; select = 2'd0; d = 4'hB;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("auto_blocked", 64'(in_ready), 64'h0);
      cyc();
    end
    chk("auto_hold", 64'(q[11:8]), 64'h9);
    q_ready = 4'b0100;
    #1;
    chk("auto_ready_pass", 64'(in_ready), 64'h1);
    exp_q[2].push_back(4'hB);
    cyc();
    in_valid = 1'b0; q_ready = '0;
    chk("auto_ptr2", 64'(q_valid), 64'h4);
    chk("auto_ptr2_data", 64'(q[11:8]), 64'hB);
    q_ready = 4'b0100;
    cyc();
    q_ready = '0;
    d = 4'hC; in_valid = 1'b1;
    exp_q[3].push_back(4'hC);
    cyc();
    in_valid = 1'b0;
    chk("auto_ptr3", 64'(q_valid), 64'h8);
    q_ready = 4'b1000;
    cyc();
    q_ready = '0;
`else
    // auto is ignored: the word follows select
    auto = 1'b1; select = 2'd3; d = 4'h5; in_valid = 1'b1;
    exp_q[3].push_back(4'h5);
    cyc();
    in_valid = 1'b0;
    chk("noauto_qvalid", 64'(q_valid), 64'h8);
    chk("noauto_data", 64'(q[15:12]), 64'h5);
    q_ready = 4'b1000;
    cyc();
    q_ready = '0;
`endif

    // all channels full, then an asynchronous reset between edges discards everything
    auto = 1'b0;
    for (int k = 0; k < 4; k++) begin
      select = 2'(k); d = 4'(k + 1); in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
    chk("full_qvalid", 64'(q_valid), 64'hF);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_qvalid", 64'(q_valid), 64'h0);
    chk("arst_q", 64'(q), 64'h0);
    chk("arst_inready", 64'(in_ready), 64'h1);
    reset = 1'b0;
    cyc();
`ifdef DEMUX_AUTO_EN
    auto = 1'b1;
    select = 2'd3;
`else
    select = 2'd0;
`endif
    d = 4'hE; in_valid = 1'b1;
    exp_q[0].push_back(4'hE);
    cyc();
    in_valid = 1'b0; auto = 1'b0;
    chk("post_arst_c0", 64'(q_valid), 64'h1);
    q_ready = 4'b0001;
    cyc();
    q_ready = '0;
    cyc();

    for (int i = 0; i < 4; i++) begin
      chk($sformatf("leftover_ch%0d", i), 64'(exp_q[i].size()), 64'h0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/demux4_seq.md
DEMUX4_SEQ -- requirements
Module: demux4_seq

Interface
REQ-001 Parameter: W, default 4, data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port d, input, W bits, input data word.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning d is offered.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts d this cycle.
REQ-007 The block SHALL have port select, input, 2 bits, target channel in manual mode.
REQ-008 The block SHALL have port auto, input, 1 bit, auto round-robin enable (see Configuration).
REQ-009 The block SHALL have port q, output, 4*W bits, where channel i occupies bits [i*W +: W].
REQ-010 The block SHALL have port q_valid, output, 4 bits, per-channel data-held flag.
REQ-011 The block SHALL have port q_ready, input, 4 bits, per-channel consumer ready.

Function
REQ-012 Each channel i SHALL hold a one-entry register buf_i and flag v_i; q[i*W +: W] = buf_i and q_valid[i] = v_i, both driven directly from registers.
REQ-013 Target t SHALL be ptr when auto mode is active, else select; t is evaluated combinationally each cycle.
REQ-014 in_ready SHALL equal (!v_t || q_ready[t]), combinational, so a full channel accepts when it drains in the same cycle.
REQ-015 Accept occurs at a rising edge with in_valid && in_ready && !reset: buf_t <= d, v_t <= 1; q_valid[t] rises 1 cycle after accept.
REQ-016 Drain occurs at a rising edge with v_i && q_ready[i]: v_i <= 0, unless the same edge accepts into i, in which case v_i stays 1 and buf_i takes the new d.
REQ-017 Channels SHALL drain independently; any subset of the four may drain on the same edge as an accept to any channel.
REQ-018 While v_i=1 and q_ready[i]=0, buf_i SHALL hold stable regardless of d, select, or in_valid.
REQ-019 in_valid with in_ready=0 SHALL cause no state change; ptr SHALL NOT advance.
REQ-020 ptr (2 bits) SHALL increment by 1 on each accept in auto mode, wrapping 3->0; it SHALL be unchanged on edges without an accept.
REQ-021 Toggling auto SHALL NOT modify ptr; on return to auto mode, distribution resumes from the retained ptr value.
REQ-022 q_ready[i] asserted with v_i=0 SHALL have no effect.

Reset
REQ-023 While reset=1: v_i=0 and buf_i=0 for all i, ptr=0, q=0, q_valid=4'b0000; no accept occurs.
REQ-024 Reset asserted mid-transfer SHALL immediately and asynchronously discard all held data.
REQ-025 After reset, in_ready=1 because all channels are empty.

Configuration
REQ-026 With macro DEMUX_AUTO_EN defined, ptr and auto mode SHALL be implemented per REQ-013, REQ-020, and REQ-021.
REQ-027 Without DEMUX_AUTO_EN, the auto port SHALL remain present but be ignored, t SHALL always equal select, and no ptr register SHALL exist.

Verification
REQ-028 Reset, then select=2, d=4'b0110, in_valid for 1 cycle, q_ready=0 -> next cycle q_valid=4'b0100 and q[11:8]=4'b0110; the value holds for 10 cycles.
REQ-029 Channel 1 full with q_ready[1]=0, select=1, in_valid=1 -> in_ready=0 and buf_1 unchanged; raise q_ready[1] with d=4'hA -> same edge drains and reloads, q[7:4]=4'hA, q_valid[1]=1.
REQ-030 With DEMUX_AUTO_EN, auto=1, q_ready=4'b1111, in_valid held 6 cycles with d=1..6 -> words land on channels 0,1,2,3,0,1; ptr=2 at the end.
REQ-031 Auto mode, channel 2 full with q_ready[2]=0, ptr=2 -> in_ready=0 and ptr stays 2 until q_ready[2] is raised.
REQ-032 All four channels full, assert reset for half a cycle between edges -> q_valid=4'b0000 and q=0 immediately, ptr=0, in_ready=1.
REQ-033 Without DEMUX_AUTO_EN, auto=1, select=3, one accept -> the word lands on channel 3.
